// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive monitor.
package uart_pkg;

   localparam int unsigned UART_DATA_BITS = 8;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;

   function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                  input int unsigned baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_rx_monitor_if.sv
// Valid/ready byte port carrying received bytes out of the monitor FIFO.
interface uart_rx_monitor_if
   import uart_pkg::*;
();

   logic [UART_DATA_BITS-1:0] rdata;
   logic                      rvalid;
   logic                      rready;

   modport master (output rdata, output rvalid, input rready);
   modport slave  (input rdata, input rvalid, output rready);

endinterface

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO; pointers carry an extra wrap bit for full/empty.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             wr_fire;
   logic             rd_fire;

   always_comb begin
      empty_o = (wr_ptr_q == rd_ptr_q);
      full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      rd_fire = rd_en_i && !empty_o;
      // A pop frees the slot the simultaneous push lands in when full.
      wr_fire = wr_en_i && (!full_o || rd_fire);
      wr_ptr_d = wr_fire ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = rd_fire ? rd_ptr_q + 1'b1 : rd_ptr_q;
      rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
      end
   end

endmodule

// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver: synchroniser, mid-bit sampling FSM, shift register and
// receive FIFO, with one-cycle framing-error and overrun pulses.
module uart_rx_monitor
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 27_000_000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               uart_rx,
   uart_rx_monitor_if.master  rx_bus,
   output logic               frame_err,
   output logic               overrun
);

   localparam int unsigned CPB   = cycles_per_bit(CLK_HZ, BAUD);
   localparam int unsigned HALF  = CPB / 2;
   localparam int unsigned CNT_W = $clog2(CPB);

   uart_rx_state_t state_q, state_d;

   logic                      sync1_q, sync2_q, prev_q;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [2:0]                bit_q, bit_d;
   logic [UART_DATA_BITS-1:0] sh_q, sh_d;
   logic                      ferr_q, ferr_d;
   logic                      ovr_q, ovr_d;
   logic                      fall;
   logic                      sample;
   logic                      push;
   logic                      pop;
   logic                      fifo_empty;
   logic                      fifo_full;

   always_comb begin
      fall   = prev_q && !sync2_q;
      sample = (state_q == START) ? (cnt_q == CNT_W'(HALF - 1))
                                  : (cnt_q == CNT_W'(CPB - 1));
      pop    = rx_bus.rvalid && rx_bus.rready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (fall) state_d = START;
         START: if (sample) state_d = sync2_q ? IDLE : DATA;
         DATA:  if (sample && bit_q == 3'd7) state_d = STOP;
         STOP:  if (sample) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d  = cnt_q + 1'b1;
      bit_d  = bit_q;
      sh_d   = sh_q;
      push   = 1'b0;
      ferr_d = 1'b0;
      ovr_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (fall) bit_d = '0;
         end
         START: begin
            if (sample) cnt_d = '0;
         end
         DATA: begin
            if (sample) begin
               cnt_d = '0;
               sh_d  = {sync2_q, sh_q[UART_DATA_BITS-1:1]};
               bit_d = bit_q + 1'b1;
            end
         end
         STOP: begin
            if (sample) begin
               cnt_d = '0;
               if (!sync2_q) begin
                  ferr_d = 1'b1;
               end else if (!fifo_full || pop) begin
                  push = 1'b1;
               end else begin
                  ovr_d = 1'b1;
               end
            end
         end
         default: cnt_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         sync1_q <= uart_rx;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   assign frame_err     = ferr_q;
   assign overrun       = ovr_q;
   assign rx_bus.rvalid = !fifo_empty;

   sync_fifo #(
      .WIDTH (UART_DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (push),
      .wr_data_i (sh_q),
      .rd_en_i   (rx_bus.rready),
      .rd_data_o (rx_bus.rdata),
      .empty_o   (fifo_empty),
      .full_o    (fifo_full)
   );

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed bench for uart_rx_monitor at the default 27 MHz / 115200 baud.
module tb_uart_rx_monitor;
   import uart_pkg::*;

   localparam int unsigned CPB      = 234;
   localparam int unsigned CPB_FAST = 228;
   localparam int unsigned STOP_AT  = 2 + 117 + 9 * 234;

   logic clk = 1'b0;
   logic rst_n;
   logic uart_rx;
   logic frame_err;
   logic overrun;

   uart_rx_monitor_if rx_bus ();

   uart_rx_monitor #(
      .CLK_HZ     (27_000_000),
      .BAUD       (115200),
      .FIFO_DEPTH (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .uart_rx   (uart_rx),
      .rx_bus    (rx_bus.master),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   int unsigned fe_cnt    = 0;
   int unsigned ov_cnt    = 0;
   int unsigned wide_cnt  = 0;
   logic        fe_prev   = 1'b0;
   logic        ov_prev   = 1'b0;
   logic [7:0]  pops[$];

   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_err) fe_cnt++;
         if (overrun) ov_cnt++;
         if ((frame_err && fe_prev) || (overrun && ov_prev)) wide_cnt++;
         if (rx_bus.rvalid && rx_bus.rready) pops.push_back(rx_bus.rdata);
      end
      fe_prev = frame_err;
      ov_prev = overrun;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive_frame(input logic [7:0] b, input logic stopb, input int unsigned bitc);
      @(negedge clk);
      uart_rx = 1'b0;
      repeat (bitc) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (bitc) @(negedge clk);
      end
      uart_rx = stopb;
      repeat (bitc) @(negedge clk);
      uart_rx = 1'b1;
   endtask

   typedef struct {
      logic [7:0]  din;
      logic        stopb;
      logic        exp_valid;
      logic [7:0]  exp_data;
      int unsigned exp_ferr;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int unsigned fe0, ov0, pb;

      vecs[0] = '{8'hA3, 1'b0, 1'b0, 8'h00, 1};
      vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
      vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
      vecs[3] = '{8'h81, 1'b1, 1'b1, 8'h81, 0};
      vecs[4] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1};

      rst_n = 1'b0;
      uart_rx = 1'b1;
      rx_bus.rready = 1'b0;
      repeat (5) @(negedge clk);
      check("reset_rvalid", 32'(rx_bus.rvalid), 32'd0);
      check("reset_rdata", 32'(rx_bus.rdata), 32'd0);
      check("reset_frame_err", 32'(frame_err), 32'd0);
      check("reset_overrun", 32'(overrun), 32'd0);
      check("reset_state", 32'(dut.state_q), 32'(IDLE));
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // 0x55: rvalid rises exactly one cycle after the stop sample.
      fork
         drive_frame(8'h55, 1'b1, CPB);
         begin
            @(negedge clk);
            repeat (STOP_AT) @(posedge clk);
            #1 check("t55_before_stop", 32'(rx_bus.rvalid), 32'd0);
            @(posedge clk);
            #1 check("t55_after_stop", 32'(rx_bus.rvalid), 32'd1);
            check("t55_rdata", 32'(rx_bus.rdata), 32'h55);
         end
      join
      repeat (20) @(negedge clk);
      check("t55_held", 32'(rx_bus.rvalid), 32'd1);
      check("t55_held_data", 32'(rx_bus.rdata), 32'h55);
      rx_bus.rready = 1'b1;
      @(negedge clk);
      rx_bus.rready = 1'b0;
      check("t55_popped", 32'(rx_bus.rvalid), 32'd0);

      // Short low pulse is rejected at the start sample.
      fe0 = fe_cnt;
      @(negedge clk);
      uart_rx = 1'b0;
      repeat (50) @(negedge clk);
      uart_rx = 1'b1;
      repeat (300) @(negedge clk);
      check("glitch_rvalid", 32'(rx_bus.rvalid), 32'd0);
      check("glitch_ferr", fe_cnt - fe0, 32'd0);
      check("glitch_state", 32'(dut.state_q), 32'(IDLE));

      for (int v = 0; v < 5; v++) begin
         fe0 = fe_cnt;
         drive_frame(vecs[v].din, vecs[v].stopb, CPB);
         repeat (5) @(negedge clk);
         check($sformatf("vec%0d_rvalid", v), 32'(rx_bus.rvalid), 32'(vecs[v].exp_valid));
         check($sformatf("vec%0d_rdata", v), 32'(rx_bus.rdata), 32'(vecs[v].exp_data));
         check($sformatf("vec%0d_ferr", v), fe_cnt - fe0, vecs[v].exp_ferr);
         if (rx_bus.rvalid) begin
            rx_bus.rready = 1'b1;
            @(negedge clk);
            rx_bus.rready = 1'b0;
         end
         check($sformatf("vec%0d_empty", v), 32'(rx_bus.rvalid), 32'd0);
      end

      // 17 bytes into a 16-entry FIFO with no consumer.
      ov0 = ov_cnt;
      fe0 = fe_cnt;
      for (int b = 0; b < 17; b++) begin
         drive_frame(8'(b), 1'b1, CPB);
         if (b == 15) check("ovr_none_before_17th", ov_cnt - ov0, 32'd0);
      end
      repeat (5) @(negedge clk);
      check("ovr_pulse", ov_cnt - ov0, 32'd1);
      check("ovr_ferr", fe_cnt - fe0, 32'd0);
      pb = pops.size();
      rx_bus.rready = 1'b1;
      repeat (24) @(negedge clk);
      rx_bus.rready = 1'b0;
      check("drain_count", pops.size() - pb, 32'd16);
      for (int i = 0; i < 16; i++) begin
         if (pb + i < pops.size())
            check($sformatf("drain_%0d", i), 32'(pops[pb + i]), 32'(i));
      end

      // Reset in the middle of 0xC3, then a clean 0x7E.
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      @(negedge clk);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      uart_rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      check("midrst_in_data", 32'(dut.state_q), 32'(DATA));
      rst_n = 1'b0;
      #1 check("midrst_state", 32'(dut.state_q), 32'(IDLE));
      repeat (3) @(negedge clk);
      uart_rx = 1'b1;
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      pb = pops.size();
      rx_bus.rready = 1'b1;
      drive_frame(8'h7E, 1'b1, CPB);
      repeat (5) @(negedge clk);
      check("midrst_pops", pops.size() - pb, 32'd1);
      if (pops.size() > pb) check("midrst_data", 32'(pops[pb]), 32'h7E);
      check("midrst_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 32'd0);

      // Three back-to-back frames about 2.5% fast.
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      pb = pops.size();
      drive_frame(8'h12, 1'b1, CPB_FAST);
      drive_frame(8'h34, 1'b1, CPB_FAST);
      drive_frame(8'hFF, 1'b1, CPB_FAST);
      repeat (5) @(negedge clk);
      rx_bus.rready = 1'b0;
      check("fast_pops", pops.size() - pb, 32'd3);
      if (pops.size() >= pb + 3) begin
         check("fast_0", 32'(pops[pb]), 32'h12);
         check("fast_1", 32'(pops[pb + 1]), 32'h34);
         check("fast_2", 32'(pops[pb + 2]), 32'hFF);
      end
      check("fast_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 32'd0);
      check("pulse_width", wide_cnt, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
